// File: rtl/obstacle_spawn_scheduler_pkg.sv
// obstacle_pkg: shared state encoding, LFSR taps and slot count for the obstacle spawn scheduler.
package obstacle_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        OVER = 2'd2
    } state_t;

    // Right-shift Galois toggle mask for x^16 + x^14 + x^13 + x^11.
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    localparam int N_SLOTS_DEF = 3;

    function automatic logic [15:0] lfsr_step(input logic [15:0] q);
        return {1'b0, q[15:1]} ^ (q[0] ? LFSR_TAPS : 16'h0000);
    endfunction

endpackage

// File: rtl/obstacle_spawn_scheduler_lfsr.sv
// spawn_lfsr16: free-running 16-bit Galois LFSR that supplies the random spawn-gap extension.
module spawn_lfsr16
    import obstacle_pkg::*;
#(
    parameter logic [15:0] SEED = 16'hACE1
)(
    input  logic        clk,
    input  logic        rst,
    output logic [15:0] q
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            q <= SEED;
        else
            q <= lfsr_step(q);
    end

endmodule

// File: rtl/obstacle_spawn_scheduler.sv
// obstacle_spawn_scheduler: times random spawn gaps, grants spawns to the lowest free slot,
// tracks slot occupancy, latches game-over on collision and ramps the speed level.
module obstacle_spawn_scheduler
    import obstacle_pkg::*;
#(
    parameter int          N_SLOTS    = N_SLOTS_DEF,
    parameter logic [7:0]  GAP_MIN    = 8'd40,
    parameter logic [7:0]  GAP_MASK   = 8'd63,
    parameter logic [15:0] LFSR_SEED  = 16'hACE1,
    parameter logic [7:0]  LEVEL_STEP = 8'd8,
    parameter logic [2:0]  MAX_LEVEL  = 3'd7
)(
    input  logic               clk,
    input  logic               rst,
    input  logic               game_en,
    input  logic               start,
    input  logic               collision,
    input  logic [N_SLOTS-1:0] slot_done,
    output logic [N_SLOTS-1:0] spawn_req,
    output logic [N_SLOTS-1:0] slot_busy,
    output logic [2:0]         speed_level,
    output logic               game_over,
    output logic [15:0]        spawn_count,
    output logic [1:0]         state
);

    state_t             cur, nxt;
    logic [15:0]        lfsr;
    logic [8:0]         gap_cnt, gap_n, gap_reload;
    logic [7:0]         level_cnt, level_n, level_inc;
    logic [N_SLOTS-1:0] busy_n, req_n, grant, busy_kept;
    logic [15:0]        count_n;
    logic [2:0]         speed_n;
    logic               any_free, restart;

    spawn_lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
        .clk (clk),
        .rst (rst),
        .q   (lfsr)
    );

    assign state      = cur;
    assign gap_reload = {1'b0, GAP_MIN} + {1'b0, lfsr[7:0] & GAP_MASK};
    assign level_inc  = level_cnt + 8'd1;
    assign busy_kept  = slot_busy & ~slot_done;

    // Grant is judged on the registered busy vector, so a slot freed this cycle waits one clk.
    always_comb begin
        grant    = '0;
        any_free = 1'b0;
        for (int i = 0; i < N_SLOTS; i++) begin
            if (!slot_busy[i] && !any_free) begin
                grant[i] = 1'b1;
                any_free = 1'b1;
            end
        end
    end

    always_comb begin
        nxt     = cur;
        busy_n  = slot_busy;
        req_n   = '0;
        gap_n   = gap_cnt;
        count_n = spawn_count;
        speed_n = speed_level;
        level_n = level_cnt;
        restart = 1'b0;
        case (cur)
            IDLE: begin
                busy_n  = busy_kept;
                restart = start;
            end
            RUN: begin
                if (collision) begin
                    nxt = OVER;
                end else begin
                    busy_n = busy_kept;
                    if (game_en && gap_cnt != 9'd0) begin
                        gap_n = gap_cnt - 9'd1;
                    end else if (game_en && any_free) begin
                        req_n   = grant;
                        busy_n  = busy_kept | grant;
                        gap_n   = gap_reload;
                        count_n = (spawn_count == 16'hFFFF) ? spawn_count : spawn_count + 16'd1;
                        level_n = (level_inc == LEVEL_STEP) ? 8'd0 : level_inc;
                        speed_n = (level_inc == LEVEL_STEP && speed_level < MAX_LEVEL) ?
                                  speed_level + 3'd1 : speed_level;
                    end
                end
            end
            OVER:    restart = start;
            default: nxt = IDLE;
        endcase
        if (restart) begin
            nxt     = RUN;
            busy_n  = '0;
            gap_n   = {1'b0, GAP_MIN};
            count_n = 16'd0;
            speed_n = 3'd0;
            level_n = 8'd0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cur         <= IDLE;
            slot_busy   <= '0;
            spawn_req   <= '0;
            gap_cnt     <= {1'b0, GAP_MIN};
            spawn_count <= 16'd0;
            speed_level <= 3'd0;
            level_cnt   <= 8'd0;
            game_over   <= 1'b0;
        end else begin
            cur         <= nxt;
            slot_busy   <= busy_n;
            spawn_req   <= req_n;
            gap_cnt     <= gap_n;
            spawn_count <= count_n;
            speed_level <= speed_n;
            level_cnt   <= level_n;
            game_over   <= (nxt == OVER);
        end
    end

endmodule

// File: tb/tb_obstacle_spawn_scheduler.sv
// tb_obstacle_spawn_scheduler: directed and randomized checks of two scheduler instances
// (short fixed gap with fast level ramp, and default random gaps) against a behavioural model.
module tb_obstacle_spawn_scheduler;

    localparam int NS = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        ge[2], st[2], col[2];
    logic [2:0]  done[2];
    logic [2:0]  req[2], busy[2], lvl[2];
    logic        over[2];
    logic [15:0] cnt[2];
    logic [1:0]  stt[2];

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    obstacle_spawn_scheduler #(
        .GAP_MIN(8'd4), .GAP_MASK(8'd0), .LEVEL_STEP(8'd2)
    ) u_dir (
        .clk(clk), .rst(rst), .game_en(ge[0]), .start(st[0]), .collision(col[0]),
        .slot_done(done[0]), .spawn_req(req[0]), .slot_busy(busy[0]),
        .speed_level(lvl[0]), .game_over(over[0]), .spawn_count(cnt[0]), .state(stt[0])
    );

    obstacle_spawn_scheduler u_rnd (
        .clk(clk), .rst(rst), .game_en(ge[1]), .start(st[1]), .collision(col[1]),
        .slot_done(done[1]), .spawn_req(req[1]), .slot_busy(busy[1]),
        .speed_level(lvl[1]), .game_over(over[1]), .spawn_count(cnt[1]), .state(stt[1])
    );

    // Behavioural model: one transaction per clk, driven by the game rules.
    int          gmin[2]  = '{4, 40};
    int          gmask[2] = '{0, 63};
    int          lstep[2] = '{2, 8};
    int          m_state[2], m_gap[2], m_cnt[2], m_lvl[2], m_lc[2];
    bit [2:0]    m_busy[2], m_req[2];
    bit [15:0]   m_lfsr[2];

    function automatic bit [15:0] poly_next(input bit [15:0] q);
        bit fb;
        bit [15:0] r;
        fb = q[0];
        r = q >> 1;
        if (fb) begin
            r[15] = 1'b1; r[13] = ~r[13]; r[12] = ~r[12]; r[10] = ~r[10];
        end
        return r;
    endfunction

    task automatic model_reset(input int k);
        m_state[k] = 0; m_gap[k] = gmin[k]; m_cnt[k] = 0; m_lvl[k] = 0; m_lc[k] = 0;
        m_busy[k] = 0; m_req[k] = 0; m_lfsr[k] = 16'hACE1;
    endtask

    task automatic model_step(input int k);
        int idx;
        m_req[k] = 0;
        if (m_state[k] != 1) begin
            if (st[k]) begin
                m_state[k] = 1; m_busy[k] = 0; m_cnt[k] = 0; m_lvl[k] = 0; m_lc[k] = 0;
                m_gap[k] = gmin[k];
            end
        end else if (col[k]) begin
            m_state[k] = 2;
        end else begin
            idx = -1;
            for (int i = NS - 1; i >= 0; i--) if (!m_busy[k][i]) idx = i;
            m_busy[k] = m_busy[k] & ~done[k];
            if (ge[k]) begin
                if (m_gap[k] > 0) m_gap[k]--;
                else if (idx >= 0) begin
                    m_req[k][idx] = 1'b1;
                    m_busy[k][idx] = 1'b1;
                    if (m_cnt[k] < 65535) m_cnt[k]++;
                    m_lc[k]++;
                    if (m_lc[k] == lstep[k]) begin
                        m_lc[k] = 0;
                        if (m_lvl[k] < 7) m_lvl[k]++;
                    end
                    m_gap[k] = gmin[k] + (int'(m_lfsr[k][7:0]) & gmask[k]);
                end
            end
        end
        m_lfsr[k] = poly_next(m_lfsr[k]);
    endtask

    always @(posedge clk or negedge rst) begin
        for (int k = 0; k < 2; k++) begin
            if (!rst) model_reset(k);
            else model_step(k);
        end
    end

    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            vectors++;
            if (req[k] !== m_req[k] || busy[k] !== m_busy[k] || lvl[k] !== 3'(m_lvl[k]) ||
                over[k] !== (m_state[k] == 2) || cnt[k] !== 16'(m_cnt[k]) || stt[k] !== 2'(m_state[k])) begin
                miscompares++;
                if (miscompares <= 20)
                    $display("FAIL model[%0d] t=%0t: req=%b busy=%b lvl=%0d over=%b cnt=%0d state=%0d, expected req=%b busy=%b lvl=%0d over=%0d cnt=%0d state=%0d",
                             k, $time, req[k], busy[k], lvl[k], over[k], cnt[k], stt[k],
                             m_req[k], m_busy[k], m_lvl[k], m_state[k] == 2, m_cnt[k], m_state[k]);
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick0(output logic [2:0] r);
        @(negedge clk) ge[0] = 1'b1;
        @(negedge clk) ge[0] = 1'b0;
        r = req[0];
        repeat (8) @(negedge clk);
    endtask

    task automatic pulse_done0(input logic [2:0] d);
        @(negedge clk) done[0] = d;
        @(negedge clk) done[0] = 3'b000;
    endtask

    task automatic run_until(input int target, input string name);
        int c;
        c = 0;
        while (m_cnt[0] < target && c < 400) begin
            ge[0] = 1'b1;
            done[0] = busy[0];
            @(negedge clk);
            c++;
        end
        ge[0] = 1'b0;
        done[0] = 3'b000;
        if (c >= 400) chk(name, c, -1);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [2:0] r;
        int c, ticks;
        logic prev_ge1;
        for (int k = 0; k < 2; k++) begin
            ge[k] = 1'b0; st[k] = 1'b0; col[k] = 1'b0; done[k] = 3'b000;
        end
        repeat (3) @(negedge clk);
        chk("reset_state", int'(stt[0]), 0);
        chk("reset_outputs", int'({req[0], busy[0], lvl[0], over[0]}), 0);
        rst = 1'b1;
        @(negedge clk) st[0] = 1'b1;
        @(negedge clk) st[0] = 1'b0;
        chk("start_run", int'(stt[0]), 1);

        // Fixed gap of 4: the counter expires after 4 ticks and the 5th tick spawns.
        for (int t = 1; t <= 15; t++) begin
            tick0(r);
            if (t == 4)  chk("no_early_spawn", int'(r), 0);
            if (t == 5)  chk("spawn_slot0", int'(r), 1);
            if (t == 10) chk("spawn_slot1", int'(r), 2);
            if (t == 15) chk("spawn_slot2", int'(r), 4);
        end
        chk("count_after_3", int'(cnt[0]), 3);
        chk("busy_after_3", int'(busy[0]), 7);
        chk("level_after_3", int'(lvl[0]), 1);

        for (int t = 16; t <= 21; t++) tick0(r);
        chk("all_busy_no_spawn", int'(r), 0);
        pulse_done0(3'b010);
        ge[0] = 1'b1;
        @(negedge clk) ge[0] = 1'b0;
        chk("deferred_spawn_slot1", int'(req[0]), 2);
        chk("level_after_4", int'(lvl[0]), 2);

        repeat (4) tick0(r);
        @(negedge clk) begin done[0] = 3'b001; ge[0] = 1'b1; end
        @(negedge clk) begin done[0] = 3'b000; ge[0] = 1'b0; end
        chk("same_cycle_free_no_spawn", int'(req[0]), 0);
        chk("slot0_freed", int'(busy[0]), 6);
        tick0(r);
        chk("next_tick_spawn_slot0", int'(r), 1);
        chk("count_after_5", int'(cnt[0]), 5);

        pulse_done0(3'b100);
        repeat (4) tick0(r);
        @(negedge clk) begin ge[0] = 1'b1; col[0] = 1'b1; end
        @(negedge clk) begin ge[0] = 1'b0; col[0] = 1'b0; end
        chk("collision_no_spawn", int'(req[0]), 0);
        chk("collision_state", int'(stt[0]), 2);
        chk("collision_game_over", int'(over[0]), 1);
        pulse_done0(3'b011);
        chk("over_ignores_done", int'(busy[0]), 3);
        @(negedge clk) st[0] = 1'b1;
        @(negedge clk) st[0] = 1'b0;
        chk("restart_state", int'(stt[0]), 1);
        chk("restart_count", int'(cnt[0]), 0);
        chk("restart_busy", int'(busy[0]), 0);

        run_until(16, "level_16_timeout");
        chk("level_at_16", int'(lvl[0]), 7);
        chk("count_at_16", int'(cnt[0]), 16);
        run_until(18, "level_18_timeout");
        chk("level_at_18", int'(lvl[0]), 7);

        c = 0;
        while (c < 50) begin
            ge[0] = 1'b1;
            done[0] = busy[0];
            @(negedge clk);
            if (req[0] != 3'b000) break;
            c++;
        end
        chk("pulse_seen_before_reset", int'(c < 50), 1);
        #2 rst = 1'b0;
        #1;
        chk("async_rst_req", int'(req[0]), 0);
        chk("async_rst_state", int'(stt[0]), 0);
        chk("async_rst_count", int'(cnt[0]), 0);
        chk("async_rst_busy_lvl_over", int'({busy[0], lvl[0], over[0]}), 0);
        ge[0] = 1'b0;
        done[0] = 3'b000;
        repeat (2) @(negedge clk);
        rst = 1'b1;

        ticks = 0;
        prev_ge1 = 1'b0;
        for (int i = 0; i < 70000; i++) begin
            @(negedge clk);
            if (prev_ge1) ticks++;
            if (req[1] != 3'b000) begin
                vectors++;
                if (ticks < 41 || ticks > 104) begin
                    miscompares++;
                    $display("FAIL random_gap: got %0d ticks between spawns, expected 41..104", ticks);
                end
                ticks = 0;
            end
            vectors++;
            if (u_rnd.u_lfsr.q == 16'h0000) begin
                miscompares++;
                $display("FAIL lfsr_nonzero: got 0 at t=%0t, expected nonzero", $time);
            end
            st[1]   = (i == 0);
            ge[1]   = (i == 0) ? 1'b0 : 1'($urandom_range(0, 1));
            prev_ge1 = ge[1];
            done[1] = busy[1];
            col[1]  = 1'b0;
            ge[0]   = ($urandom_range(0, 2) == 0);
            done[0] = 3'($urandom) & (($urandom_range(0, 7) == 0) ? 3'b111 : 3'b000);
            col[0]  = ($urandom_range(0, 499) == 0);
            st[0]   = ($urandom_range(0, 99) == 0);
        end
        chk("random_spawned", int'(cnt[1] > 16'd300), 1);
        for (int k = 0; k < 2; k++) begin
            ge[k] = 1'b0; st[k] = 1'b0; col[k] = 1'b0; done[k] = 3'b000;
        end
        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
